// File: rtl/gen_clock_tree.sv
// rtl/gen_clock_tree.sv - prescaled binary down-counter clock generator with rise and frame strobes
module gen_clock_tree #(
    parameter int N_STAGES = 3,
    parameter int PRE_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sync,
    input  logic [PRE_W-1:0]    pre_div,
    output logic [N_STAGES-1:0] clk_div,
    output logic [N_STAGES-1:0] rise_stb,
    output logic                frame_stb
);

    localparam logic [N_STAGES-1:0] CNT_ZERO = '0;
    localparam logic [PRE_W-1:0]    PCNT_ZERO = '0;

    // Prescaler position and the ratio latched for the current frame.
    logic [PRE_W-1:0]    pcnt;
    logic [PRE_W-1:0]    pre_act;

    // Stage counter; clk_div is this register driven straight to the port.
    logic [N_STAGES-1:0] cnt;

    // Next-cycle helpers derived from current state.
    logic                tick;
    logic [N_STAGES-1:0] cnt_dec;
    logic                frame_edge;
    logic [N_STAGES-1:0] rise_next;

    // Decide whether this cycle is a base tick and what the counter becomes on it.
    always_comb begin
        tick       = 1'b0;
        cnt_dec    = cnt - 1'b1;
        frame_edge = 1'b0;
        rise_next  = '0;
        if (en && !sync && (pcnt == pre_act)) begin
            tick = 1'b1;
        end
        // Wrapping from zero to all-ones is the frame boundary where a new ratio may land.
        frame_edge = (cnt == CNT_ZERO);
        // A bit rises exactly where the decremented value has a 1 that the old value did not.
        rise_next  = ~cnt & cnt_dec;
    end

    // State and registered outputs: reset beats sync beats enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt      <= PCNT_ZERO;
            pre_act   <= pre_div;
            cnt       <= CNT_ZERO;
            rise_stb  <= '0;
            frame_stb <= 1'b0;
        end else if (sync) begin
            // Realign so the very next tick starts a fresh frame.
            pcnt      <= PCNT_ZERO;
            pre_act   <= pre_div;
            cnt       <= CNT_ZERO;
            rise_stb  <= '0;
            frame_stb <= 1'b0;
        end else if (en) begin
            if (tick) begin
                pcnt      <= PCNT_ZERO;
                cnt       <= cnt_dec;
                rise_stb  <= rise_next;
                frame_stb <= frame_edge;
                // Ratio changes only at a frame boundary, where pcnt is also cleared,
                // so no half-period is ever shortened or stretched.
                if (frame_edge) begin
                    pre_act <= pre_div;
                end
            end else begin
                pcnt      <= pcnt + 1'b1;
                rise_stb  <= '0;
                frame_stb <= 1'b0;
            end
        end else begin
            // Frozen: all counting state holds, strobes drop.
            rise_stb  <= '0;
            frame_stb <= 1'b0;
        end
    end

    assign clk_div = cnt;

endmodule

// File: tb/tb_gen_clock_tree.sv
// tb/tb_gen_clock_tree.sv - scoreboard bench for gen_clock_tree
module tb_gen_clock_tree;

    localparam int N  = 3;
    localparam int PW = 8;
    localparam int M  = 1 << N;

    typedef struct {
        logic [N-1:0] div;
        logic [N-1:0] rise;
        logic         frame;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          sync = 1'b0;
    logic [PW-1:0] pre_div = '0;
    logic [N-1:0]  clk_div;
    logic [N-1:0]  rise_stb;
    logic          frame_stb;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int m_pcnt = 0;
    int m_pre  = 0;
    int m_cnt  = 0;

    exp_t sb[$];

    gen_clock_tree #(.N_STAGES(N), .PRE_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .pre_div   (pre_div),
        .clk_div   (clk_div),
        .rise_stb  (rise_stb),
        .frame_stb (frame_stb)
    );

    always #5 clk = ~clk;

    task automatic check_int(input int got, input int want, input string tag);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic r, input logic e, input logic s, input logic [PW-1:0] pd, input string tag);
        exp_t x;
        int   old;
        reset   = r;
        en      = e;
        sync    = s;
        pre_div = pd;
        x.rise  = '0;
        x.frame = 1'b0;
        if (r || s) begin
            m_pcnt = 0;
            m_cnt  = 0;
            m_pre  = int'(pd);
        end else if (e) begin
            if (m_pcnt == m_pre) begin
                old    = m_cnt;
                m_cnt  = (m_cnt + M - 1) % M;
                m_pcnt = 0;
                x.frame = (old == 0);
                for (int k = 0; k < N; k++)
                    x.rise[k] = (((old >> k) & 1) == 0) && (((m_cnt >> k) & 1) == 1);
                if (m_cnt == M - 1)
                    m_pre = int'(pd);
            end else begin
                m_pcnt++;
            end
        end
        x.div = m_cnt[N-1:0];
        sb.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        x = sb.pop_front();
        checks++;
        assert (clk_div === x.div) else begin
            errors++;
            $error("FAIL %s clk_div cyc=%0d got=%b exp=%b", tag, cyc, clk_div, x.div);
        end
        checks++;
        assert (rise_stb === x.rise) else begin
            errors++;
            $error("FAIL %s rise_stb cyc=%0d got=%b exp=%b", tag, cyc, rise_stb, x.rise);
        end
        checks++;
        assert (frame_stb === x.frame) else begin
            errors++;
            $error("FAIL %s frame_stb cyc=%0d got=%b exp=%b", tag, cyc, frame_stb, x.frame);
        end
    endtask

    initial begin
        int          tbl[9];
        int          last_a;
        int          last_b;
        logic        prev0;
        logic [N-1:0] prevd;

        // Reset state.
        step(1, 0, 0, 8'd0, "reset");
        step(1, 1, 0, 8'd0, "reset_en");

        // Undivided sequence from reset: 111,110,...,000,111.
        tbl = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 8'd0, "seq");
            check_int(int'(clk_div), tbl[i], "seq_const");
            check_int(int'(frame_stb), (i == 0 || i == 8) ? 1 : 0, "seq_frame");
            check_int(int'(rise_stb[2]), (i == 0 || i == 8) ? 1 : 0, "seq_rise2");
        end

        // Prescale by 3: bit0 toggles every 3 clk, bit2 rises every 24 clk.
        step(1, 0, 0, 8'd2, "rst_pd2");
        last_a = -1;
        last_b = -1;
        prev0  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 0, 8'd2, "pd2");
            if (clk_div[0] !== prev0) begin
                if (last_a >= 0) check_int(cyc - last_a, 3, "pd2_toggle");
                last_a = cyc;
                prev0  = clk_div[0];
            end
            if (rise_stb[2]) begin
                if (last_b >= 0) check_int(cyc - last_b, 24, "pd2_period2");
                last_b = cyc;
            end
        end

        // Ratio change mid-frame lands only at the next frame boundary.
        step(1, 0, 0, 8'd0, "rst_chg");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'd0, "chg_old");
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'd3, "chg_drain");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'd3, "chg_new");
            check_int(int'(clk_div), 7, "chg_hold");
        end
        step(0, 1, 0, 8'd3, "chg_new");
        check_int(int'(clk_div), 6, "chg_tick");
        for (int i = 0; i < 20; i++) step(0, 1, 0, 8'd0, "chg_after");

        // Freeze for 5 cycles then resume.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'd0, "freeze");
        for (int i = 0; i < 12; i++) step(0, 1, 0, 8'd0, "resume");

        // Sync while disabled, then first tick gives a frame.
        step(0, 0, 1, 8'd3, "sync_dis");
        check_int(int'(clk_div), 0, "sync_zero");
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'd3, "sync_run");

        // Reset and sync together; ticks every 6 clk afterwards.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'd1, "pre_rs");
        step(1, 1, 1, 8'd5, "rst_sync");
        last_a = cyc;
        prevd  = '0;
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 0, 8'd5, "pd5");
            if (clk_div !== prevd) begin
                check_int(cyc - last_a, 6, "pd5_tick");
                last_a = cyc;
                prevd  = clk_div;
            end
        end

        // Maximum ratio: a tick every 256 clk.
        step(0, 1, 1, 8'hff, "sync_max");
        last_a = cyc;
        prevd  = '0;
        for (int i = 0; i < 520; i++) begin
            step(0, 1, 0, 8'hff, "pdmax");
            if (clk_div !== prevd) begin
                check_int(cyc - last_a, 256, "pdmax_tick");
                last_a = cyc;
                prevd  = clk_div;
            end
        end

        // Mixed random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), 8'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
